// File: rtl/mem_stage_if.sv
// EX/MEM input bus and MEM-stage result/feedback signals for mem_stage.
// MEM_ALIGN_CHECK_EN adds the misalign pulse output.
interface mem_stage_if;
  logic [140:0] exmem;
  logic [103:0] memwb;
  logic         pcsrc;
  logic [31:0]  target;
  logic         stall;
`ifdef MEM_ALIGN_CHECK_EN
  logic         misalign;

  modport master (output exmem, input memwb, pcsrc, target, stall, misalign);
  modport slave  (input exmem, output memwb, pcsrc, target, stall, misalign);
`else
  modport master (output exmem, input memwb, pcsrc, target, stall);
  modport slave  (input exmem, output memwb, pcsrc, target, stall);
`endif
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-addressed data memory with MEM_LAT-cycle access, branch resolution, MEM/WB register.
// Optional feature macro MEM_ALIGN_CHECK_EN: suppress misaligned loads/stores and pulse bus.misalign.
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input logic        CLK,
  input logic        RST,
  mem_stage_if.slave bus
);
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  localparam bit         MULTI  = (MEM_LAT > 1);

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        jump;
    logic        memtoreg;
    logic        regwrite;
    logic        branch;
    logic        memwrite;
    logic        memread;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic [31:0] target;
  } exmem_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ldata;
  } memwb_t;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  exmem_t      req_q, req_d;
  memwb_t      memwb_q, memwb_d;
  logic        pcsrc_q, pcsrc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mem_q [DEPTH];

  exmem_t        in_bus, cur;
  logic          access, is_store, is_load, misal, complete, mem_we, stall;
  logic [AW-1:0] idx;

  // While BUSY the latched request is authoritative; the live bus is ignored.
  assign in_bus   = exmem_t'(bus.exmem);
  assign cur      = (state_q == BUSY) ? req_q : in_bus;
  assign access   = cur.valid & (cur.memread | cur.memwrite);
  assign is_store = access & cur.memwrite;
  assign is_load  = access & ~cur.memwrite;
  assign idx      = cur.alu[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misal        = access & (cur.alu[1:0] != 2'b00);
  assign bus.misalign = misalign_q;
`else
  assign misal = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    memwb_d  = '0;
    pcsrc_d  = 1'b0;
    target_d = target_q;
    mem_we   = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (access && !misal && MULTI) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
          req_d   = in_bus;
          stall   = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      memwb_d.instr    = cur.instr;
      memwb_d.valid    = cur.valid;
      memwb_d.memtoreg = cur.memtoreg;
      memwb_d.regwrite = cur.valid & cur.regwrite & ~misal;
      memwb_d.dest     = cur.dest;
      memwb_d.alu      = cur.alu;
      if (misal)        memwb_d.ldata = 32'hDEAD_BEEF;
      else if (is_load) memwb_d.ldata = mem_q[idx];
      mem_we   = is_store & ~misal;
      pcsrc_d  = cur.valid & (cur.jump | (cur.branch & cur.zero));
      target_d = cur.target;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_d = misal;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      memwb_q  <= '0;
      pcsrc_q  <= 1'b0;
      target_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      memwb_q  <= memwb_d;
      pcsrc_q  <= pcsrc_d;
      target_q <= target_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // NOTE: the data array has no reset; RST only blocks the write so an aborted store is lost.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) mem_q[idx] <= cur.wdata;
  end

  assign bus.memwb  = memwb_q;
  assign bus.pcsrc  = pcsrc_q;
  assign bus.target = target_q;
  assign bus.stall  = stall;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one MEM_LAT=1 and one MEM_LAT=3 instance against a behavioural model.
module tb_mem_stage;
  localparam int DEPTH = 256;
  localparam logic [5:0] C_NOP = 6'b000000;
  localparam logic [5:0] C_LD  = 6'b011001; // memtoreg, regwrite, memread
  localparam logic [5:0] C_ST  = 6'b000010;
  localparam logic [5:0] C_BR  = 6'b000100;
  localparam logic [5:0] C_JMP = 6'b100000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if if1 ();
  mem_stage_if if3 ();

  mem_stage #(.DEPTH(DEPTH), .MEM_LAT(1)) dut1 (.CLK(clk), .RST(rst), .bus(if1));
  mem_stage #(.DEPTH(DEPTH), .MEM_LAT(3)) dut3 (.CLK(clk), .RST(rst), .bus(if3));

  int checks = 0;
  int errors = 0;
  logic [31:0] mem1 [DEPTH];
  logic [31:0] mem3 [DEPTH];

  task automatic check(input string tag, input logic [140:0] obs, input logic [140:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [140:0] mk(input logic valid, input logic [5:0] ctrl, input logic zero,
                                      input logic [31:0] alu, input logic [31:0] wdata,
                                      input logic [4:0] dest, input logic [31:0] target);
    logic [31:0] instr;
    instr = $urandom;
    return {instr, valid, ctrl, zero, alu, wdata, dest, target};
  endfunction

  function automatic logic [140:0] rnd141();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[140:0];
  endfunction

  // Reference: what WB must see for one instruction, and the memory side effect.
  task automatic model(input logic [140:0] x, input bit use3,
                       output logic [103:0] wb, output logic pc, output logic mis);
    logic        valid, rd, wr, acc;
    logic [31:0] alu, ld;
    int          word;
    valid = x[108];
    rd    = x[102];
    wr    = x[103];
    alu   = x[100:69];
    acc   = valid & (rd | wr);
    word  = int'((alu / 32'd4) % DEPTH);
    mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && (alu % 4 != 0);
`endif
    ld = 32'd0;
    if (mis)              ld = 32'hDEAD_BEEF;
    else if (acc && !wr)  ld = use3 ? mem3[word] : mem1[word];
    if (acc && wr && !mis) begin
      if (use3) mem3[word] = x[68:37];
      else      mem1[word] = x[68:37];
    end
    wb = {x[140:109], valid, x[106], valid & x[105] & ~mis, x[36:32], alu, ld};
    pc = valid & (x[107] | (x[104] & x[101]));
  endtask

  task automatic op1(input logic [140:0] x);
    logic [103:0] wb;
    logic pc, mis;
    model(x, 1'b0, wb, pc, mis);
    if1.exmem = x;
    #1;
    check("stall1_accept", if1.stall, 0);
    @(posedge clk); #1;
    check("memwb1", if1.memwb, wb);
    check("pcsrc1", if1.pcsrc, pc);
    if (pc) check("target1", if1.target, x[31:0]);
`ifdef MEM_ALIGN_CHECK_EN
    check("misalign1", if1.misalign, mis);
`endif
    check("stall1_done", if1.stall, 0);
    if1.exmem = '0;
  endtask

  task automatic op3(input logic [140:0] x);
    logic [103:0] wb;
    logic pc, mis, multi;
    model(x, 1'b1, wb, pc, mis);
    multi = x[108] & (x[102] | x[103]) & ~mis;
    if3.exmem = x;
    #1;
    check("stall3_accept", if3.stall, multi);
    if (multi) begin
      for (int k = 1; k < 3; k++) begin
        @(posedge clk); #1;
        check("bubble3_valid", if3.memwb[71], 0);
        check("bubble3_pcsrc", if3.pcsrc, 0);
        check("stall3_busy", if3.stall, 1);
        if3.exmem = rnd141();
      end
    end
    @(posedge clk); #1;
    check("memwb3", if3.memwb, wb);
    check("pcsrc3", if3.pcsrc, pc);
    if (pc) check("target3", if3.target, x[31:0]);
`ifdef MEM_ALIGN_CHECK_EN
    check("misalign3", if3.misalign, mis);
`endif
    if3.exmem = '0;
    #1;
    check("stall3_done", if3.stall, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [140:0] x;

    rst = 1'b1;
    if1.exmem = '0;
    if3.exmem = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_memwb1", if1.memwb, 0);
    check("rst_pcsrc1", if1.pcsrc, 0);
    check("rst_target1", if1.target, 0);
    check("rst_stall1", if1.stall, 0);
    check("rst_memwb3", if3.memwb, 0);
    check("rst_pcsrc3", if3.pcsrc, 0);
    check("rst_target3", if3.target, 0);
    check("rst_stall3", if3.stall, 0);
    rst = 1'b0;

    // Give every word a known value (upper address bits random to exercise wrap).
    for (int i = 0; i < DEPTH; i++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'(i << 2);
      op1(mk(1'b1, C_ST, 1'b0, a, $urandom, 5'd0, 32'd0));
      op3(mk(1'b1, C_ST, 1'b0, a, $urandom, 5'd0, 32'd0));
    end

    // Single-cycle store then load, no stall.
    op1(mk(1'b1, C_ST, 1'b0, 32'h40, 32'h1234_5678, 5'd0, 32'd0));
    op1(mk(1'b1, C_LD, 1'b0, 32'h40, 32'd0, 5'd5, 32'd0));
    check("ld40_data", if1.memwb[31:0], 32'h1234_5678);
    check("ld40_dest", if1.memwb[68:64], 5'd5);
    check("ld40_regwrite", if1.memwb[69], 1);

    // Branch resolution.
    op1(mk(1'b1, C_BR, 1'b1, $urandom, 32'd0, 5'd0, 32'h100));
    check("br_taken", if1.pcsrc, 1);
    check("br_target", if1.target, 32'h100);
    op1(mk(1'b1, C_NOP, 1'b0, $urandom, 32'd0, 5'd0, 32'd0));
    check("br_one_cycle", if1.pcsrc, 0);
    op1(mk(1'b1, C_BR, 1'b0, $urandom, 32'd0, 5'd0, 32'h200));
    check("br_not_taken", if1.pcsrc, 0);
    op1(mk(1'b0, C_JMP | C_ST, 1'b0, 32'h44, 32'hFFFF_FFFF, 5'd3, 32'h300));
    check("invalid_jump", if1.pcsrc, 0);
    check("invalid_regwrite", if1.memwb[69], 0);

    // Address wrap-around.
    op1(mk(1'b1, C_ST, 1'b0, 32'h400, 32'hAA, 5'd0, 32'd0));
    op1(mk(1'b1, C_LD, 1'b0, 32'h000, 32'd0, 5'd1, 32'd0));
    check("wrap_load", if1.memwb[31:0], 32'hAA);

    // Multi-cycle: load, load that also branches, store immediately followed by load.
    op3(mk(1'b1, C_LD, 1'b0, 32'h40, 32'd0, 5'd7, 32'd0));
    check("lat3_valid", if3.memwb[71], 1);
    op3(mk(1'b1, C_LD | C_BR, 1'b1, 32'h44, 32'd0, 5'd8, 32'h0000_0ABC));
    op3(mk(1'b1, C_ST, 1'b0, 32'h80, 32'h0BAD_F00D, 5'd0, 32'd0));
    op3(mk(1'b1, C_LD, 1'b0, 32'h80, 32'd0, 5'd9, 32'd0));
    check("lat3_st_ld", if3.memwb[31:0], 32'h0BAD_F00D);

    // Reset in the middle of a 3-cycle store: the store must not land.
    if3.exmem = mk(1'b1, C_ST, 1'b0, 32'h10, 32'hCAFE_F00D, 5'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    if3.exmem = '0;
    #1;
    check("abort_memwb", if3.memwb, 0);
    check("abort_stall", if3.stall, 0);
    check("abort_pcsrc", if3.pcsrc, 0);
    rst = 1'b0;
    op3(mk(1'b1, C_LD, 1'b0, 32'h10, 32'd0, 5'd2, 32'd0));
    check("abort_old_data", if3.memwb[31:0], mem3[4]);

`ifdef MEM_ALIGN_CHECK_EN
    op1(mk(1'b1, C_ST, 1'b0, 32'h41, 32'h5555_5555, 5'd4, 32'd0));
    check("mis_pulse", if1.misalign, 1);
    check("mis_data", if1.memwb[31:0], 32'hDEAD_BEEF);
    check("mis_regwrite", if1.memwb[69], 0);
    op1(mk(1'b1, C_LD, 1'b0, 32'h40, 32'd0, 5'd4, 32'd0));
    check("mis_mem_kept", if1.memwb[31:0], 32'h1234_5678);
    op3(mk(1'b1, C_LD, 1'b0, 32'h43, 32'd0, 5'd4, 32'd0));
`endif

    // Randomized traffic on both instances.
    for (int n = 0; n < 150; n++) begin
      x = mk($urandom_range(0, 3) != 0, 6'($urandom), 1'($urandom), $urandom, $urandom,
             5'($urandom), $urandom);
      op1(x);
      x = mk($urandom_range(0, 3) != 0, 6'($urandom), 1'($urandom), $urandom, $urandom,
             5'($urandom), $urandom);
      op3(x);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
